pipelined_adder_tree: RTL
=========================

# pipelined_adder_tree

Parametrised, fully pipelined N-input adder tree with a valid/ready handshake. It generalises the fixed 3-stage, 8-input, 8-bit tree in the following ways:
- operand count and width are set by parameters;
- the output is width-extended, so sums never overflow;
- signed or unsigned arithmetic is selectable;
- backpressure stalls the whole pipeline without losing data.

It sits between the operand source and any downstream consumer of reduced sums.

## Interface
- `N_INPUTS`, default 8: operand count; power of two, ≥ 2.
- `DATA_W`, default 8: width of each operand.
- `SIGNED`, default 0: 1 = two's-complement operands, 0 = unsigned.
- `LEVELS` (localparam) = log2(`N_INPUTS`); `SUM_W` (localparam) = `DATA_W` + `LEVELS`.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  `N_INPUTS`*`DATA_W`  operands, flattened; operand i occupies bits [i*`DATA_W` +: `DATA_W`].
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `out_sum`  out  `SUM_W`  sum of one accepted operand vector.
- `out_valid`  out  1  `out_sum` is valid.
- `out_ready`  in  1  consumer accepts `out_sum` this cycle.

## Operation
- **Tree structure:** `LEVELS` register levels.
  - Level 1 holds `N_INPUTS`/2 pairwise sums of the operands.
  - Level k holds pairwise sums of level k-1.
  - Level `LEVELS` is `out_sum`.
  - No input register stage.
- **Extension:** every operand is extended to `SUM_W` before the first add.
  - Sign-extended when `SIGNED`=1, zero-extended when 0.
  - All adds are `SUM_W` wide; the result is exact, with no truncation or wrap.
- **Pairing:** level-1 node j = operand 2j + operand 2j+1. The same pattern applies at every level.
- **Valid tracking:** each level has a valid bit.
  - A level's data registers load only when the pipeline advances and the previous level's valid is 1.
  - Otherwise data holds, so `out_sum` keeps its last valid result.
- **Advance:** `adv` = !`out_valid` | `out_ready`.
  - When `adv`=1, every valid bit shifts one level; level-1 valid takes `in_valid`.
  - When `adv`=0, all levels hold, whether valid or bubble.
- **Handshake:**
  - `in_ready` = `adv` (combinational from `out_ready` and `out_valid`).
  - A vector is accepted when `in_valid` & `in_ready`.
  - A result is consumed when `out_valid` & `out_ready`.
  - Order is preserved; no result is dropped or duplicated.
- **Bubbles:**
  - `in_valid`=0 during `adv` inserts a bubble.
  - Bubbles are not compressed while the output is valid and stalled; the whole pipe freezes.
- **Reset (`rst`=0):**
  - Asynchronously clears all valid bits and all data registers.
  - `out_sum`=0, `out_valid`=0, hence `in_ready`=1 (combinational) while in reset.
  - Reset mid-operation discards all in-flight vectors; none emerge after release.
- **Handshake rule:** `in_data`/`in_valid` changes while `in_ready`=0 have no effect.

## Timing
- **Latency:** a vector accepted at edge t produces `out_valid`=1 with its `out_sum` after edge t+`LEVELS`-1, i.e. visible in the cycle following edge t+`LEVELS`-1 when no stall occurs. For `N_INPUTS`=8 that is 3 cycles from presentation.
- **Throughput:** one vector per cycle while `out_ready`=1.
- **Stall:**
  - Each cycle with `out_valid`=1 & `out_ready`=0 adds exactly one cycle of latency to every in-flight vector.
  - `out_sum` is stable throughout the stall.
- **Simultaneous consume and accept:** with `out_valid`=1, `out_ready`=1, `in_valid`=1, the pipe advances, so a new result and a new acceptance occur in the same cycle.
- **Reset release:** first acceptance is possible on the first rising edge with `rst`=1.

## Test plan
(Defaults unless noted.)
- **Basic sum:** operands 1..8, single vector, `out_ready`=1 → `out_valid` pulses one cycle at latency 3, `out_sum`=11'h024; `out_sum` holds 11'h024 afterwards.
- **Unsigned full scale:** all operands 8'hFF → `out_sum`=11'h7F8, no overflow.
- **Signed, `SIGNED`=1:**
  - all operands 8'h80 → `out_sum`=11'h400 (−1024);
  - operands {8'h7F, 8'h81, 0,…} → 11'h000.
- **Backpressure:**
  - Stream vectors summing to 0x010, 0x020, 0x030 back-to-back; drop `out_ready` for 2 cycles while the first is valid.
  - → `in_ready`=0 those cycles, `out_sum`=0x010 held, then 0x010, 0x020, 0x030 delivered in order, none lost.
- **Bubbles:** `in_valid` alternating 1/0 → `out_valid` alternates 1/0 with latency 3.
- **Reset mid-flight:** accept 2 vectors, assert `rst`=0 for 1 cycle before either emerges.
  - → `out_valid`=0, `out_sum`=0 immediately (asynchronous);
  - no `out_valid` for 5 cycles after release with `in_valid`=0.
- **Parameter sweep:** `N_INPUTS`=2 and `N_INPUTS`=16 with `DATA_W`=12 → latencies 1 and 4, random vectors match a reference model.

Source files
------------

// File: rtl/pipelined_adder_tree_if.sv
// Operand-vector / reduced-sum handshake bundle for pipelined_adder_tree.
// master drives operands and consumer ready; slave is the adder tree itself.
interface pipelined_adder_tree_if #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 8,
    parameter int SUM_W    = DATA_W + $clog2(N_INPUTS)
);
    logic [N_INPUTS*DATA_W-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [SUM_W-1:0]           out_sum;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_valid
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Purpose: N-input width-extended adder tree, signed or unsigned, one register per tree level.
// Latency: LEVELS cycles from acceptance to out_valid; one vector per cycle throughput.
// Backpressure: a stalled valid output freezes every level (bubbles included); in_ready = !out_valid | out_ready.
module pipelined_adder_tree #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 8,
    parameter bit SIGNED   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_adder_tree_if.slave bus
);
    localparam int LEVELS = $clog2(N_INPUTS);
    localparam int SUM_W  = DATA_W + LEVELS;

    // Tree nodes in heap order: node[1] is the root, children of node i are 2i and 2i+1;
    // indices N_INPUTS..2*N_INPUTS-1 would be the operands, held separately in ext.
    logic [SUM_W-1:0]  ext  [N_INPUTS];
    logic [SUM_W-1:0]  node [1:N_INPUTS-1];
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS:0]   vld_chain;
    logic              adv;

    // vld_chain[k] is the valid bit of level k, with level 0 being the input port.
    assign vld_chain     = {vld_q, bus.in_valid};
    assign adv           = !vld_chain[LEVELS] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_chain[LEVELS];
    assign bus.out_sum   = node[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_chain[LEVELS-1:0];
        end
    end

    for (genvar p = 0; p < N_INPUTS; p++) begin : g_ext
        logic [DATA_W-1:0] op;
        assign op = bus.in_data[p*DATA_W +: DATA_W];
        if (SIGNED) begin : g_sext
            assign ext[p] = {{LEVELS{op[DATA_W-1]}}, op};
        end else begin : g_zext
            assign ext[p] = {{LEVELS{1'b0}}, op};
        end
    end

    for (genvar i = 1; i < N_INPUTS; i++) begin : g_node
        // Node i sits in level LEVELS - floor(log2(i)); level 1 is nearest the operands.
        localparam int LVL = LEVELS + 1 - $clog2(i + 1);
        logic [SUM_W-1:0] lhs;
        logic [SUM_W-1:0] rhs;

        if (2 * i >= N_INPUTS) begin : g_leaf
            assign lhs = ext[2*i - N_INPUTS];
            assign rhs = ext[2*i + 1 - N_INPUTS];
        end else begin : g_inner
            assign lhs = node[2*i];
            assign rhs = node[2*i + 1];
        end

        // Data only moves with a valid token, so out_sum keeps its last result across bubbles.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                node[i] <= '0;
            end else if (adv && vld_chain[LVL-1]) begin
                node[i] <= lhs + rhs;
            end
        end
    end
endmodule
